// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue.
package fetch_pkg;

  localparam int          FQ_DEPTH_DEFAULT = 8;
  localparam int          FQ_XLEN          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Circular entry array: one paired write (two adjacent entries) and two adjacent reads.
module fetch_queue_storage #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata0_i,
  input  logic [W-1:0]             wdata1_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata0_o,
  output logic [W-1:0]             rdata1_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] waddr1;
  logic [AW-1:0] raddr1;

  // Adjacent addresses wrap naturally because DEPTH is a power of two.
  assign waddr1 = waddr_i + AW'(1);
  assign raddr1 = raddr_i + AW'(1);

  // NOTE: the array has no reset; validity is tracked by the pointer/count state.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata0_i;
      mem_q[waddr1]  <= wdata1_i;
    end
  end

  assign rdata0_o = mem_q[raddr_i];
  assign rdata1_o = mem_q[raddr1];

endmodule

// File: rtl/fetch_queue_dual.sv
// Fetch-to-decode queue: pair enqueue, 0/1/2 dequeue with slot-0 realignment, flush.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue_dual
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid_i,
  input  logic [XLEN-1:0]          enq_pc_i,
  input  logic [XLEN-1:0]          enq_instr0_i,
  input  logic [XLEN-1:0]          enq_instr1_i,
  output logic                     enq_ready_o,
  output logic                     deq0_valid_o,
  output logic [XLEN-1:0]          deq0_pc_o,
  output logic [XLEN-1:0]          deq0_instr_o,
  output logic                     deq1_valid_o,
  output logic [XLEN-1:0]          deq1_pc_o,
  output logic [XLEN-1:0]          deq1_instr_o,
  input  logic [1:0]               deq_count_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              enq_fire;
  logic              bypass;
  logic [1:0]        deq_req;
  logic [CW-1:0]     avail;
  logic [CW-1:0]     deq_n;
  logic [XLEN-1:0]   enq_pc1;
  logic [2*XLEN-1:0] rdata0, rdata1;

  assign enq_pc1     = enq_pc_i + XLEN'(4);
  assign enq_ready_o = (count_q <= CW'(DEPTH - 2));
  assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && enq_valid_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed pair is consumable in the same cycle it arrives.
  assign avail   = bypass ? CW'(2) : count_q;
  assign deq_req = (deq_count_i == 2'd3) ? 2'd2 : deq_count_i;
  assign deq_n   = (CW'(deq_req) < avail) ? CW'(deq_req) : avail;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + AW'(2);
      rd_ptr_d = rd_ptr_q + AW'(deq_n);
      count_d  = count_q + (enq_fire ? CW'(2) : CW'(0)) - deq_n;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_storage #(
    .DEPTH (DEPTH),
    .W     (2 * XLEN)
  ) u_storage (
    .clk      (clk),
    .we_i     (enq_fire),
    .waddr_i  (wr_ptr_q),
    .wdata0_i ({enq_pc_i, enq_instr0_i}),
    .wdata1_i ({enq_pc1, enq_instr1_i}),
    .raddr_i  (rd_ptr_q),
    .rdata0_o (rdata0),
    .rdata1_o (rdata1)
  );

  always_comb begin
    deq0_valid_o = 1'b0;
    deq0_pc_o    = '0;
    deq0_instr_o = XLEN'(NOP_INSTR);
    deq1_valid_o = 1'b0;
    deq1_pc_o    = '0;
    deq1_instr_o = XLEN'(NOP_INSTR);
    if (bypass) begin
      deq0_valid_o = 1'b1;
      deq0_pc_o    = enq_pc_i;
      deq0_instr_o = enq_instr0_i;
      deq1_valid_o = 1'b1;
      deq1_pc_o    = enq_pc1;
      deq1_instr_o = enq_instr1_i;
    end else begin
      if (count_q >= CW'(1)) begin
        deq0_valid_o = 1'b1;
        {deq0_pc_o, deq0_instr_o} = rdata0;
      end
      if (count_q >= CW'(2)) begin
        deq1_valid_o = 1'b1;
        {deq1_pc_o, deq1_instr_o} = rdata1;
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_fetch_queue_dual.sv
// Directed bench for fetch_queue_dual (DEPTH=8); bypass checks follow FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue_dual;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic [31:0] enq_pc, enq_instr0, enq_instr1;
  logic        enq_ready;
  logic        deq0_valid, deq1_valid;
  logic [31:0] deq0_pc, deq0_instr, deq1_pc, deq1_instr;
  logic [1:0]  deq_count;
  logic        flush;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_queue_dual #(.DEPTH(8), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .enq_valid_i  (enq_valid),
    .enq_pc_i     (enq_pc),
    .enq_instr0_i (enq_instr0),
    .enq_instr1_i (enq_instr1),
    .enq_ready_o  (enq_ready),
    .deq0_valid_o (deq0_valid),
    .deq0_pc_o    (deq0_pc),
    .deq0_instr_o (deq0_instr),
    .deq1_valid_o (deq1_valid),
    .deq1_pc_o    (deq1_pc),
    .deq1_instr_o (deq1_instr),
    .deq_count_i  (deq_count),
    .flush_i      (flush),
    .count_o      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, clock it, then return inputs to idle 1ns after the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [1:0] dc, input logic fl);
    enq_valid  = v;
    enq_pc     = pc;
    enq_instr0 = 32'hA000_0000 | pc;
    enq_instr1 = 32'hB000_0000 | pc;
    deq_count  = dc;
    flush      = fl;
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    deq_count = 2'd0;
    flush     = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enq_valid = 1'b0; enq_pc = '0; enq_instr0 = '0; enq_instr1 = '0;
    deq_count = 2'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(enq_ready), 32'd1);
    check("rst_v0", 32'(deq0_valid), 32'd0);
    check("rst_v1", 32'(deq1_valid), 32'd0);
    check("rst_pc0", deq0_pc, 32'h0);
    check("rst_instr0", deq0_instr, NOP);
    check("rst_instr1", deq1_instr, NOP);

    // Fill to DEPTH with four pairs, then a rejected fifth
    step(1'b1, 32'h100, 2'd0, 1'b0);
    check("fill1_count", 32'(count), 32'd2);
    check("fill1_pc0", deq0_pc, 32'h100);
    check("fill1_pc1", deq1_pc, 32'h104);
    check("fill1_instr1", deq1_instr, 32'hB000_0100);
    step(1'b1, 32'h108, 2'd0, 1'b0);
    step(1'b1, 32'h110, 2'd0, 1'b0);
    check("fill3_ready", 32'(enq_ready), 32'd1);
    step(1'b1, 32'h118, 2'd0, 1'b0);
    check("full_count", 32'(count), 32'd8);
    check("full_ready", 32'(enq_ready), 32'd0);
    step(1'b1, 32'h120, 2'd0, 1'b0);
    check("full_reject_count", 32'(count), 32'd8);
    check("full_reject_pc0", deq0_pc, 32'h100);

    // deq_count=3 behaves as 2
    step(1'b0, 32'h0, 2'd3, 1'b0);
    check("deq3_count", 32'(count), 32'd6);
    check("deq3_pc0", deq0_pc, 32'h108);
    check("deq3_ready", 32'(enq_ready), 32'd1);

    // count=6: enqueue and dequeue 2 together, storage wraps
    step(1'b1, 32'h140, 2'd2, 1'b0);
    check("simul_count", 32'(count), 32'd6);
    check("simul_pc0", deq0_pc, 32'h110);
    step(1'b0, 32'h0, 2'd2, 1'b0);
    check("drain1_pc0", deq0_pc, 32'h118);
    step(1'b0, 32'h0, 2'd2, 1'b0);
    check("wrap_pc0", deq0_pc, 32'h140);
    check("wrap_pc1", deq1_pc, 32'h144);
    check("wrap_instr0", deq0_instr, 32'hA000_0140);
    step(1'b0, 32'h0, 2'd2, 1'b0);
    check("drained_count", 32'(count), 32'd0);
    check("drained_v0", 32'(deq0_valid), 32'd0);

    // Single issue realigns the leftover into slot 0
    step(1'b1, 32'h200, 2'd0, 1'b0);
    step(1'b0, 32'h0, 2'd1, 1'b0);
    check("realign_pc0", deq0_pc, 32'h204);
    check("realign_instr0", deq0_instr, 32'hB000_0200);
    check("realign_v0", 32'(deq0_valid), 32'd1);
    check("realign_v1", 32'(deq1_valid), 32'd0);
    check("realign_pc1", deq1_pc, 32'h0);
    check("realign_instr1", deq1_instr, NOP);
    check("realign_count", 32'(count), 32'd1);
    step(1'b0, 32'h0, 2'd2, 1'b0);
    check("clamp_count", 32'(count), 32'd0);
    step(1'b0, 32'h0, 2'd2, 1'b0);
    check("empty_deq_count", 32'(count), 32'd0);

    // Flush with count=5 drops the concurrent enqueue
    step(1'b1, 32'h400, 2'd0, 1'b0);
    step(1'b1, 32'h408, 2'd0, 1'b0);
    step(1'b1, 32'h410, 2'd1, 1'b0);
    check("preflush_count", 32'(count), 32'd5);
    step(1'b1, 32'h500, 2'd0, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_v0", 32'(deq0_valid), 32'd0);
    check("flush_v1", 32'(deq1_valid), 32'd0);
    step(1'b1, 32'h600, 2'd0, 1'b0);
    check("postflush_count", 32'(count), 32'd2);
    check("postflush_pc0", deq0_pc, 32'h600);

    // Reset mid-operation discards contents
    rst = 1'b0;
    step(1'b1, 32'h700, 2'd0, 1'b0);
    rst = 1'b1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_v0", 32'(deq0_valid), 32'd0);
    check("midrst_instr0", deq0_instr, NOP);

    // Empty-queue enqueue: same-cycle visibility only with bypass
    enq_valid = 1'b1; enq_pc = 32'h300;
    enq_instr0 = 32'hA000_0300; enq_instr1 = 32'hB000_0300;
`ifdef FETCH_QUEUE_BYPASS_EN
    deq_count = 2'd2;
    #1;
    check("byp_v0", 32'(deq0_valid), 32'd1);
    check("byp_v1", 32'(deq1_valid), 32'd1);
    check("byp_pc0", deq0_pc, 32'h300);
    check("byp_pc1", deq1_pc, 32'h304);
    check("byp_instr1", deq1_instr, 32'hB000_0300);
    step(1'b1, 32'h300, 2'd2, 1'b0);
    check("byp_after_count", 32'(count), 32'd0);
    check("byp_after_v0", 32'(deq0_valid), 32'd0);
`else
    deq_count = 2'd0;
    #1;
    check("nobyp_v0", 32'(deq0_valid), 32'd0);
    check("nobyp_pc0", deq0_pc, 32'h0);
    step(1'b1, 32'h300, 2'd0, 1'b0);
    check("nobyp_after_count", 32'(count), 32'd2);
    check("nobyp_after_pc1", deq1_pc, 32'h304);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
